// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with NZCV flags and an iterative
// shift-add multiplier. Single-cycle ops present their result in the cycle
// after acceptance. MUL occupies the block for n/MUL_RADIX iterations.
//
// Handshake: an operation transfers in on a rising CLK edge where
// in_valid && in_ready, and a result transfers out on an edge where
// out_valid && out_ready. in_ready is combinational:
// (state==IDLE) || (state==DONE && out_ready). A DONE result is held
// stable until it is taken.
module alu_seq #(
  parameter int n         = 64,
  parameter int MUL_RADIX = 1
) (
  input  logic         CLK,
  input  logic         Reset_L,
  input  logic [n-1:0] BusA,
  input  logic [n-1:0] BusB,
  input  logic [3:0]   ALUCtrl,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] result,
  output logic [3:0]   flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   state_o
);

  localparam int ITERS = n / MUL_RADIX;
  localparam int CW    = $clog2(ITERS);
  localparam int SW    = $clog2(n);
  localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);
  localparam logic [n-1:0]  N_LIM     = n'(n);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LSL   = 4'b0011;
  localparam logic [3:0] OP_LSR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [n-1:0]   result_q;
  logic [3:0]     flags_q;
  logic           out_valid_q;
  logic [n-1:0]   acc_q;
  logic [n-1:0]   mcand_q;
  logic [n-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;

  logic [n:0]     add_full;
  logic [n:0]     sub_full;
  logic           shift_big;
  logic [n-1:0]   alu_res_d;
  logic           alu_c_d;
  logic           alu_v_d;
  logic [3:0]     alu_flags_d;
  logic [n-1:0]   mul_acc_d;
  logic           accept;
  logic           op_is_mul;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign op_is_mul = (ALUCtrl == OP_MUL);

  assign result    = result_q;
  assign flags     = flags_q;
  assign out_valid = out_valid_q;
  assign state_o   = state_q;

  // Subtraction is A + ~B + 1 so the carry out reads as "no borrow".
  assign add_full  = {1'b0, BusA} + {1'b0, BusB};
  assign sub_full  = {1'b0, BusA} + {1'b0, ~BusB} + (n+1)'(1);
  // The whole BusB is the shift amount; anything >= n clears the result.
  assign shift_big = (BusB >= N_LIM);

  // Single-cycle result and NZCV flags from the live operand buses.
  always_comb begin
    alu_res_d = '0;
    alu_c_d   = 1'b0;
    alu_v_d   = 1'b0;
    case (ALUCtrl)
      OP_AND:   alu_res_d = BusA & BusB;
      OP_OR:    alu_res_d = BusA | BusB;
      OP_ADD: begin
        alu_res_d = add_full[n-1:0];
        alu_c_d   = add_full[n];
        alu_v_d   = (BusA[n-1] == BusB[n-1]) && (add_full[n-1] != BusA[n-1]);
      end
      OP_SUB: begin
        alu_res_d = sub_full[n-1:0];
        alu_c_d   = sub_full[n];
        alu_v_d   = (BusA[n-1] != BusB[n-1]) && (sub_full[n-1] != BusA[n-1]);
      end
      OP_LSL:   alu_res_d = shift_big ? '0 : (BusA << BusB[SW-1:0]);
      OP_LSR:   alu_res_d = shift_big ? '0 : (BusA >> BusB[SW-1:0]);
      OP_PASSB: alu_res_d = BusB;
      default:  alu_res_d = '0;
    endcase
    alu_flags_d = {alu_res_d[n-1], (alu_res_d == '0), alu_c_d, alu_v_d};
  end

  // One multiply iteration: add the partial products of the low
  // MUL_RADIX multiplier bits into the accumulator.
  always_comb begin
    mul_acc_d = acc_q;
    for (int i = 0; i < MUL_RADIX; i++) begin
      if (mplier_q[i]) begin
        mul_acc_d = mul_acc_d + (mcand_q << i);
      end
    end
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q     <= IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else if (accept) begin
      if (op_is_mul) begin
        state_q     <= MUL;
        out_valid_q <= 1'b0;
        acc_q       <= '0;
        mcand_q     <= BusA;
        mplier_q    <= BusB;
        cnt_q       <= '0;
      end else begin
        state_q     <= DONE;
        result_q    <= alu_res_d;
        flags_q     <= alu_flags_d;
        out_valid_q <= 1'b1;
      end
    end else begin
      case (state_q)
        MUL: begin
          acc_q    <= mul_acc_d;
          mcand_q  <= mcand_q << MUL_RADIX;
          mplier_q <= mplier_q >> MUL_RADIX;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            state_q     <= DONE;
            result_q    <= mul_acc_d;
            flags_q     <= {mul_acc_d[n-1], (mul_acc_d == '0), 2'b00};
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a behavioural model.
module tb_alu_seq;

  localparam int N = 64;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LSL   = 4'b0011;
  localparam logic [3:0] OP_LSR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;

  // ---------------- clock / reset ----------------
  logic         CLK = 1'b0;
  logic         Reset_L;
  logic [N-1:0] BusA, BusB;
  logic [3:0]   ALUCtrl;
  logic         in_valid, in_ready;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic         out_valid, out_ready;
  logic [1:0]   state_dbg;

  logic [N-1:0] a4, b4, result4;
  logic [3:0]   op4, flags4;
  logic         in_valid4, in_ready4, out_valid4, out_ready4;
  logic [1:0]   state_dbg4;

  always #5 CLK = ~CLK;

  alu_seq #(.n(N), .MUL_RADIX(1)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl),
    .in_valid(in_valid), .in_ready(in_ready), .result(result), .flags(flags),
    .out_valid(out_valid), .out_ready(out_ready), .state_o(state_dbg)
  );

  alu_seq #(.n(N), .MUL_RADIX(4)) dut4 (
    .CLK(CLK), .Reset_L(Reset_L), .BusA(a4), .BusB(b4), .ALUCtrl(op4),
    .in_valid(in_valid4), .in_ready(in_ready4), .result(result4), .flags(flags4),
    .out_valid(out_valid4), .out_ready(out_ready4), .state_o(state_dbg4)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;
  logic [N+3:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: {N,Z,C,V,result} from plain arithmetic.
  function automatic logic [N+3:0] model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0]      r;
    logic              c, v;
    logic signed [N:0] s;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_ADD: begin
        {c, r} = {1'b0, a} + {1'b0, b};
        s = $signed({a[N-1], a}) + $signed({b[N-1], b});
        v = (s[N] != s[N-1]);
      end
      OP_SUB: begin
        r = a - b;
        c = (a >= b);
        s = $signed({a[N-1], a}) - $signed({b[N-1], b});
        v = (s[N] != s[N-1]);
      end
      OP_LSL:   r = (b >= 64'(N)) ? '0 : (a << b);
      OP_LSR:   r = (b >= 64'(N)) ? '0 : (a >> b);
      OP_PASSB: r = b;
      OP_MUL:   r = a * b;
      default:  r = '0;
    endcase
    return {r[N-1], (r == '0), c, v, r};
  endfunction

  // Scoreboard: predict at each input transfer, compare at each output transfer.
  always @(negedge CLK) begin
    if (!Reset_L) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0h expected no output", {flags, result});
        end else begin
          check("sb", {flags, result}, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(ALUCtrl, BusA, BusB));
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one op with out_ready=1; return result, flags, accept-to-out_valid
  // latency and the number of waiting cycles that showed in_ready=1.
  task automatic do_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] r, output logic [3:0] f, output int lat, output int busy_bad);
    bit acc;
    acc = 0;
    busy_bad = 0;
    ALUCtrl = op; BusA = a; BusB = b; in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 100 && !acc; t++) begin
      #1;
      acc = in_ready;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_bad++;
      @(posedge CLK); #1;
      lat++;
    end
    r = result;
    f = flags;
  endtask

  function automatic logic [N-1:0] rand64();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(N-1){1'b0}}};
      3: return {1'b0, {(N-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic [3:0]   fl;
    int           lat;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [N-1:0] r, exp_r, r0;
    logic [3:0]   f, f0;
    int           lat, busy_bad, stale;
    logic [3:0]   opl[10];

    vecs[0]  = '{"add_ovf",   OP_ADD,   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001, 1};
    vecs[1]  = '{"sub_eq",    OP_SUB,   64'd5, 64'd5, 64'd0, 4'b0110, 1};
    vecs[2]  = '{"sub_borrow",OP_SUB,   64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1};
    vecs[3]  = '{"lsl_63",    OP_LSL,   64'd1, 64'd63, 64'h8000_0000_0000_0000, 4'b1000, 1};
    vecs[4]  = '{"lsl_64",    OP_LSL,   64'd1, 64'd64, 64'd0, 4'b0100, 1};
    vecs[5]  = '{"lsr_4",     OP_LSR,   64'hF0, 64'd4, 64'h0F, 4'b0000, 1};
    vecs[6]  = '{"lsr_200",   OP_LSR,   64'hDEAD_BEEF_1234_5678, 64'd200, 64'd0, 4'b0100, 1};
    vecs[7]  = '{"mul_wrap",  OP_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 65};
    vecs[8]  = '{"mul_3x5",   OP_MUL,   64'd3, 64'd5, 64'd15, 4'b0000, 65};
    vecs[9]  = '{"and",       OP_AND,   64'hF0F0, 64'hFF00, 64'hF000, 4'b0000, 1};
    vecs[10] = '{"or",        OP_OR,    64'h0F, 64'hF0, 64'hFF, 4'b0000, 1};
    vecs[11] = '{"passb",     OP_PASSB, 64'd0, 64'h123, 64'h123, 4'b0000, 1};
    vecs[12] = '{"op_1111",   4'b1111,  64'd7, 64'd9, 64'd0, 4'b0100, 1};
    vecs[13] = '{"add_carry", OP_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110, 1};
    vecs[14] = '{"sub_ovf",   OP_SUB,   64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1};
    vecs[15] = '{"lsl_0",     OP_LSL,   64'hA5, 64'd0, 64'hA5, 4'b0000, 1};
    vecs[16] = '{"op_0101",   4'b0101,  64'd3, 64'd4, 64'd0, 4'b0100, 1};

    // ---- reset ----
    Reset_L = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    BusA = '0; BusB = '0; ALUCtrl = '0;
    a4 = '0; b4 = '0; op4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    Reset_L = 1'b1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_flags", flags, 4'b0000);
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // ---- vector table ----
    for (int i = 0; i < 17; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat, busy_bad);
      check({vecs[i].name, "_res"}, r, vecs[i].res);
      check({vecs[i].name, "_flags"}, f, vecs[i].fl);
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      if (vecs[i].op == OP_MUL) check({vecs[i].name, "_busy_in_ready"}, busy_bad, 0);
    end
    @(posedge CLK); #1;

    // ---- reset in the middle of MUL 3*5 ----
    ALUCtrl = OP_MUL; BusA = 64'd3; BusB = 64'd5; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    Reset_L = 1'b0;
    @(posedge CLK); #1;
    check("midmul_out_valid", out_valid, 1'b0);
    check("midmul_result", result, '0);
    check("midmul_flags", flags, 4'b0000);
    Reset_L = 1'b1;
    #1;
    check("midmul_in_ready", in_ready, 1'b1);
    stale = 0;
    repeat (80) begin
      @(posedge CLK); #1;
      if (out_valid) stale++;
    end
    check("midmul_no_stale", stale, 0);

    // ---- backpressure ----
    out_ready = 1'b0;
    ALUCtrl = OP_OR; BusA = 64'h0F00; BusB = 64'h00F0; in_valid = 1'b1;
    @(posedge CLK); #1;
    ALUCtrl = OP_AND; BusA = 64'hFF00; BusB = 64'h0F0F;
    check("bp_valid", out_valid, 1'b1);
    r0 = result; f0 = flags;
    check("bp_or_res", r0, 64'h0FF0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      @(posedge CLK); #1;
      check("bp_hold_res", result, r0);
      check("bp_hold_flags", flags, f0);
      check("bp_hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1'b1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    check("bp_and_valid", out_valid, 1'b1);
    check("bp_and_res", result, 64'h0F00);
    @(posedge CLK); #1;

    // ---- throughput: 8 PassB with an unknown opcode mid-stream ----
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ALUCtrl = (k == 4) ? 4'b1111 : OP_PASSB;
      BusA = {$urandom, $urandom};
      BusB = {$urandom, $urandom} | 64'h1;
      exp_r = (k == 4) ? '0 : BusB;
      @(posedge CLK); #1;
      check("tp_valid", out_valid, 1'b1);
      check("tp_res", result, exp_r);
      if (k == 4) check("tp_unknown_flags", flags, 4'b0100);
    end
    in_valid = 1'b0;
    @(posedge CLK); #1;

    // ---- MUL_RADIX=4 latency ----
    op4 = OP_MUL; a4 = 64'h1234_5678_9ABC_DEF1; b4 = 64'h0FED_CBA9_8765_4321; in_valid4 = 1'b1;
    #1;
    check("r4_in_ready", in_ready4, 1'b1);
    @(posedge CLK); #1;
    in_valid4 = 1'b0;
    lat = 1; busy_bad = 0;
    while (!out_valid4 && lat < 100) begin
      if (in_ready4) busy_bad++;
      @(posedge CLK); #1;
      lat++;
    end
    check("r4_lat", lat, 17);
    check("r4_busy_in_ready", busy_bad, 0);
    check("r4_res", result4, model(OP_MUL, 64'h1234_5678_9ABC_DEF1, 64'h0FED_CBA9_8765_4321) & {4'b0, {N{1'b1}}});

    // ---- randomized traffic checked by the scoreboard ----
    opl = '{OP_AND, OP_OR, OP_ADD, OP_LSL, OP_LSR, OP_SUB, OP_PASSB, OP_ADD, OP_SUB, 4'b1111};
    for (int cyc = 0; cyc < 700; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ALUCtrl   = ($urandom_range(0, 15) == 0) ? OP_MUL : opl[$urandom_range(0, 9)];
      BusA      = rand64();
      if ((ALUCtrl == OP_LSL || ALUCtrl == OP_LSR) && $urandom_range(0, 3) != 0)
        BusB = 64'($urandom_range(0, 70));
      else
        BusB = rand64();
      @(posedge CLK); #1;
    end

    // ---- drain ----
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 100 && (exp_q.size() != 0 || out_valid); t++) begin
      @(posedge CLK); #1;
    end
    check("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, handshaked, parametrised successor to the datapath ALU.
- Adds NZCV flags, an iterative multiply, and valid/ready flow control on both sides.
- Sits between operand read and writeback in the multi-cycle datapath.
- Single-cycle ops complete one cycle after acceptance; MUL is iterative and stalls the pipe.

Parameters:
- n, 64, operand/result width; power of two, 8..64.
- MUL_RADIX, 1, multiplier bits retired per iteration; must divide n (1, 2 or 4).

Ports:
- CLK  input  1  rising-edge clock.
- Reset_L  input  1  synchronous active-low reset.
- BusA  input  n  operand A.
- BusB  input  n  operand B / shift amount.
- ALUCtrl  input  4  opcode.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block accepts operation this cycle.
- result  output  n  registered result.
- flags  output  4  {N,Z,C,V}, registered with result.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer takes result this cycle.

Behaviour:
- Opcodes (unchanged encodings):
  - AND 0000, OR 0001, ADD 0010, LSL 0011, LSR 0100, SUB 0110, PassB 0111.
  - New: MUL 1000, returns low n bits of unsigned BusA*BusB.
  - Any other code completes in 1 cycle with result 0 and flags {0,1,0,0}.
- Reset (Reset_L low at posedge, in any state, including mid-MUL):
  - state=IDLE; result=0, flags=0, out_valid=0.
  - Multiplier accumulator and counter cleared; in-flight operation discarded.
  - in_ready=1 in the first cycle after release.
- Accept: operation accepted on a posedge with in_valid && in_ready. Operands latched; later BusA/BusB/ALUCtrl changes are ignored until the next accept.
- in_ready (combinational) = (state==IDLE) || (state==DONE && out_ready).
- States:
  - IDLE: accept of a non-MUL op -> DONE, result/flags written at the accept edge (latency 1). Accept of MUL -> MUL.
  - MUL: shift-add, MUL_RADIX multiplier bits per cycle, counter 0..n/MUL_RADIX-1. On the final iteration -> DONE with result written. Accept-to-out_valid latency is n/MUL_RADIX+1 cycles (65 at defaults). in_ready=0 throughout.
  - DONE: out_valid=1; result/flags held stable while out_ready=0.
    - out_ready=1 with no new accept -> IDLE, out_valid=0.
    - out_ready=1 with accept of a non-MUL op -> stay in DONE with new result (back-to-back, 1 op/cycle).
    - out_ready=1 with accept of MUL -> MUL, out_valid=0.
- Shifts:
  - Amount is the full BusB value, unsigned.
  - BusB >= n yields result 0 (no modulo wrap).
  - BusB==0 passes BusA.
- Flags:
  - N=result[n-1] and Z=(result==0) for all ops.
  - ADD: C = carry out of bit n-1; V = signed overflow (operand signs equal, result sign differs).
  - SUB: computed as BusA + ~BusB + 1. C=1 when no borrow (BusA >= BusB unsigned). V = signed overflow (operand signs differ, result sign differs from A).
  - All other ops, including MUL: C=0, V=0.
- Arithmetic wraps modulo 2^n; MUL high half discarded.

Test Plan:
- Reset mid-MUL:
  - Accept MUL 3*5, assert Reset_L=0 at cycle 10.
  - Required: out_valid=0, result=0, flags=0 next cycle; in_ready=1 after release; no stale result ever appears.
- ADD/SUB flags (n=64):
  - ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> result 0x8000_0000_0000_0000, flags N=1 Z=0 C=0 V=1.
  - SUB 5-5 -> result 0, flags {0,1,1,0}.
  - SUB 0-1 -> result all-ones, flags {1,0,0,0}.
- Shifts:
  - LSL 1 by 63 -> 0x8000_0000_0000_0000, N=1.
  - LSL 1 by 64 -> 0, Z=1.
  - LSR 0xF0 by 4 -> 0x0F.
  - LSR any value by 200 -> 0.
- MUL latency and wrap:
  - MUL 0xFFFF_FFFF_FFFF_FFFF * 2 -> 0xFFFF_FFFF_FFFF_FFFE.
  - out_valid exactly 65 cycles after accept (MUL_RADIX=1); 17 cycles with MUL_RADIX=4.
  - in_ready=0 during iteration.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after an OR result.
  - Required: result/flags stable, in_ready=0, new in_valid ignored.
  - On out_ready=1 with in_valid=1 (AND), the next result appears the following cycle with out_valid unbroken.
- Throughput:
  - Stream 8 PassB ops with in_valid=out_ready=1.
  - Required: one result per cycle, values equal BusB in order, unknown opcode 1111 mid-stream returns 0 with Z=1.
